// File: rtl/game_ctrl_if.sv
// Signal bundle between the VGA/sprite front end and the game controller.
// The controller sits on the slave side of this bundle.
interface game_ctrl_if;
    logic       start;
    logic       vga_v_sync;
    logic       inDisplayArea;
    logic       pix_player;
    logic       pix_block;
    logic [1:0] state;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       hit;
    logic       new_round;

    modport master (
        output start, vga_v_sync, inDisplayArea, pix_player, pix_block,
        input  state, p1_score, p2_score, hit, new_round
    );

    modport slave (
        input  start, vga_v_sync, inDisplayArea, pix_player, pix_block,
        output state, p1_score, p2_score, hit, new_round
    );
endinterface

// File: rtl/game_ctrl.sv
// Two-player survival game controller. Each player earns one point for every
// SURVIVE_FRAMES collision-free frames; a collision or reaching SCORE_MAX ends the turn.
module game_ctrl #(
    parameter int SURVIVE_FRAMES = 64,
    parameter int SCORE_MAX      = 10
) (
    input  logic        clk,
    input  logic        reset,
    game_ctrl_if.slave  bus
);
    localparam int             CW       = $clog2(SURVIVE_FRAMES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SURVIVE_FRAMES - 1);
    localparam logic [3:0]     SMAX     = 4'(SCORE_MAX);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    state_t        state_q, state_n;
    logic [3:0]    p1_q, p1_n, p2_q, p2_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          hit_q, hit_n, nr_q, nr_n;
    logic          end_pend_q, end_pend_n;

    logic vs_q, fb, start_low_q, start_r, coll;
    logic in_game, pix_coll;

    assign in_game  = (state_q == QGAME_1) || (state_q == QGAME_2);
    assign pix_coll = bus.pix_player & bus.pix_block & bus.inDisplayArea & in_game;

    // start_low_q stays 0 out of reset so a switch already on cannot look like a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q        <= 1'b0;
            fb          <= 1'b0;
            start_low_q <= 1'b0;
            start_r     <= 1'b0;
            coll        <= 1'b0;
        end else begin
            vs_q        <= bus.vga_v_sync;
            fb          <= vs_q & ~bus.vga_v_sync;
            start_low_q <= ~bus.start;
            start_r     <= bus.start & start_low_q;
            if (fb)
                coll <= pix_coll;
            else if (pix_coll)
                coll <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= QI;
            p1_q       <= '0;
            p2_q       <= '0;
            cnt_q      <= '0;
            hit_q      <= 1'b0;
            nr_q       <= 1'b0;
            end_pend_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            p1_q       <= p1_n;
            p2_q       <= p2_n;
            cnt_q      <= cnt_n;
            hit_q      <= hit_n;
            nr_q       <= nr_n;
            end_pend_q <= end_pend_n;
        end
    end

    logic [3:0] cur_score, score_n;
    logic       turn_end;

    // A collision pulses hit while still in the turn and ends the turn one
    // cycle later, so hit never overlaps new_round or shows up in QDONE.
    always_comb begin
        state_n    = state_q;
        p1_n       = p1_q;
        p2_n       = p2_q;
        cnt_n      = cnt_q;
        hit_n      = 1'b0;
        nr_n       = 1'b0;
        end_pend_n = 1'b0;
        turn_end   = 1'b0;
        cur_score  = (state_q == QGAME_2) ? p2_q : p1_q;
        score_n    = cur_score;

        case (state_q)
            QI: begin
                if (start_r) begin
                    state_n = QGAME_1;
                    p1_n    = '0;
                    p2_n    = '0;
                    cnt_n   = '0;
                    nr_n    = 1'b1;
                end
            end
            QGAME_1, QGAME_2: begin
                if (!bus.start) begin
                    state_n = QDONE;
                end else if (end_pend_q) begin
                    turn_end = 1'b1;
                end else if (fb) begin
                    if (coll) begin
                        hit_n      = 1'b1;
                        end_pend_n = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_n   = '0;
                        score_n = cur_score + 4'd1;
                        if (score_n == SMAX)
                            turn_end = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end

                if (state_q == QGAME_1)
                    p1_n = score_n;
                else
                    p2_n = score_n;

                if (turn_end) begin
                    if (state_q == QGAME_1) begin
                        state_n = QGAME_2;
                        cnt_n   = '0;
                        nr_n    = 1'b1;
                    end else begin
                        state_n = QDONE;
                    end
                end
            end
            QDONE: begin
                if (!bus.start)
                    state_n = QI;
            end
            default: state_n = QI;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.p1_score  = p1_q;
    assign bus.p2_score  = p2_q;
    assign bus.hit       = hit_q;
    assign bus.new_round = nr_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: two instances (default and small parameters) on shared
// stimulus, checked against a frame-level model of the scoring rules.
module tb_game_ctrl;
    logic clk = 1'b0;
    logic reset, start, vs, disp, pp, pb;

    always #5 clk = ~clk;

    game_ctrl_if bus_a();
    game_ctrl_if bus_b();

    assign bus_a.start = start;          assign bus_b.start = start;
    assign bus_a.vga_v_sync = vs;        assign bus_b.vga_v_sync = vs;
    assign bus_a.inDisplayArea = disp;   assign bus_b.inDisplayArea = disp;
    assign bus_a.pix_player = pp;        assign bus_b.pix_player = pp;
    assign bus_a.pix_block = pb;         assign bus_b.pix_block = pb;

    game_ctrl #(.SURVIVE_FRAMES(64), .SCORE_MAX(10)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    game_ctrl #(.SURVIVE_FRAMES(2),  .SCORE_MAX(3))  dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    logic [1:0] o_st  [2];
    logic [3:0] o_p1  [2];
    logic [3:0] o_p2  [2];
    logic       o_hit [2];
    logic       o_nr  [2];
    assign o_st[0] = bus_a.state;     assign o_st[1] = bus_b.state;
    assign o_p1[0] = bus_a.p1_score;  assign o_p1[1] = bus_b.p1_score;
    assign o_p2[0] = bus_a.p2_score;  assign o_p2[1] = bus_b.p2_score;
    assign o_hit[0] = bus_a.hit;      assign o_hit[1] = bus_b.hit;
    assign o_nr[0] = bus_a.new_round; assign o_nr[1] = bus_b.new_round;

    int sf[2]   = '{64, 2};
    int smax[2] = '{10, 3};

    // Frame-level reference: state 0 idle, 1/2 player turn, 3 done.
    int m_st[2]   = '{0, 0};
    int m_p1[2]   = '{0, 0};
    int m_p2[2]   = '{0, 0};
    int m_surv[2] = '{0, 0};
    int m_hit[2]  = '{0, 0};
    int m_nr[2]   = '{0, 0};

    int hit_cnt[2] = '{0, 0};
    int nr_cnt[2]  = '{0, 0};
    int viol = 0;
    int ncmp = 0;
    int nfail = 0;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (o_hit[d] === 1'b1) hit_cnt[d]++;
            if (o_nr[d] === 1'b1) nr_cnt[d]++;
            if ((o_hit[d] === 1'b1 && o_nr[d] === 1'b1) ||
                ((o_hit[d] === 1'b1 || o_nr[d] === 1'b1) && (o_st[d] == 2'b00 || o_st[d] == 2'b11)))
                viol++;
        end
    end

    function automatic logic [9:0] exp_tuple(input int d);
        return {2'(m_st[d]), 4'(m_p1[d]), 4'(m_p2[d])};
    endfunction

    function automatic logic [9:0] obs_tuple(input int d);
        return {o_st[d], o_p1[d], o_p2[d]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_end(input int d);
        if (m_st[d] == 1) begin
            m_st[d] = 2;
            m_surv[d] = 0;
            m_nr[d]++;
        end else begin
            m_st[d] = 3;
        end
    endtask

    task automatic model_frame(input bit col);
        for (int d = 0; d < 2; d++) begin
            if (m_st[d] == 1 || m_st[d] == 2) begin
                if (col) begin
                    m_hit[d]++;
                    model_end(d);
                end else begin
                    m_surv[d]++;
                    if (m_surv[d] == sf[d]) begin
                        m_surv[d] = 0;
                        if (m_st[d] == 1) m_p1[d]++; else m_p2[d]++;
                        if ((m_st[d] == 1 ? m_p1[d] : m_p2[d]) == smax[d]) model_end(d);
                    end
                end
            end
        end
    endtask

    // One frame of 8 cycles, v_sync low in slots 4-5; optional collision in slot cs.
    task automatic run_frame(input int cs, input bit vis);
        for (int s = 0; s < 8; s++) begin
            vs = !(s == 4 || s == 5);
            if (s == cs) begin
                pp = 1'b1; pb = 1'b1; disp = vis;
            end else begin
                pp = 1'($urandom);
                pb = pp ? 1'b0 : 1'($urandom);
                disp = 1'($urandom);
            end
            cyc();
        end
        pp = 1'b0; pb = 1'b0;
    endtask

    task automatic do_stop();
        start = 1'b0;
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) m_st[d] = 0;
    endtask

    task automatic do_start();
        start = 1'b0;
        repeat (2) cyc();
        start = 1'b1;
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 1; m_p1[d] = 0; m_p2[d] = 0; m_surv[d] = 0; m_nr[d]++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; vs = 1'b0; disp = 1'b1; pp = 1'b1; pb = 1'b1;
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (obs_tuple(d) !== 10'd0 || o_hit[d] !== 1'b0 || o_nr[d] !== 1'b0) begin
                nfail++;
                $display("FAIL reset_state dut%0d: got st/p1/p2=%h hit=%b nr=%b, need 000 0 0", d, obs_tuple(d), o_hit[d], o_nr[d]);
            end
        end
        reset = 1'b0; vs = 1'b1; pp = 1'b0; pb = 1'b0;
        repeat (6) cyc();
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (o_st[d] !== 2'b00) begin
                nfail++;
                $display("FAIL start_held_through_reset dut%0d: got state %b, need 00", d, o_st[d]);
            end
        end
    endtask

    task automatic test_start();
        do_start();
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (obs_tuple(d) !== exp_tuple(d) || o_st[d] !== 2'b01 || nr_cnt[d] !== 1) begin
                nfail++;
                $display("FAIL start_rise dut%0d: got %h nr=%0d, need %h nr=1", d, obs_tuple(d), nr_cnt[d], exp_tuple(d));
            end
        end
    endtask

    task automatic test_survive();
        for (int f = 1; f <= 64; f++) begin
            run_frame(-1, 1'b0);
            model_frame(1'b0);
            if (f == 6 || f == 12 || f == 64) begin
                for (int d = 0; d < 2; d++) begin
                    ncmp++;
                    if (obs_tuple(d) !== exp_tuple(d)) begin
                        nfail++;
                        $display("FAIL survive_f%0d dut%0d: got %h, need %h", f, d, obs_tuple(d), exp_tuple(d));
                    end
                end
            end
            if (f == 6) begin
                ncmp++;
                if (o_st[1] !== 2'b10 || o_p1[1] !== 4'd3) begin
                    nfail++;
                    $display("FAIL small_p1_max: got st=%b p1=%0d, need st=10 p1=3", o_st[1], o_p1[1]);
                end
            end
            if (f == 12) begin
                ncmp++;
                if (o_st[1] !== 2'b11 || o_p2[1] !== 4'd3) begin
                    nfail++;
                    $display("FAIL small_p2_max: got st=%b p2=%0d, need st=11 p2=3", o_st[1], o_p2[1]);
                end
            end
        end
        ncmp++;
        if (o_p1[0] !== 4'd1 || o_st[0] !== 2'b01) begin
            nfail++;
            $display("FAIL default_64_frames: got p1=%0d st=%b, need p1=1 st=01", o_p1[0], o_st[0]);
        end
    endtask

    task automatic test_collision();
        run_frame(2, 1'b0);          // outside display area: ignored
        model_frame(1'b0);
        run_frame(5, 1'b1);          // on the frame-boundary cycle: counts next frame
        model_frame(1'b0);
        ncmp++;
        if (hit_cnt[0] !== 0 || o_st[0] !== 2'b01) begin
            nfail++;
            $display("FAIL no_hit_yet: got hits=%0d st=%b, need hits=0 st=01", hit_cnt[0], o_st[0]);
        end
        run_frame(-1, 1'b0);
        model_frame(1'b1);
        ncmp++;
        if (hit_cnt[0] !== 1 || nr_cnt[0] !== 2 || o_st[0] !== 2'b10 || o_p1[0] !== 4'd1) begin
            nfail++;
            $display("FAIL carried_hit: got hits=%0d nr=%0d st=%b p1=%0d, need 1 2 10 1", hit_cnt[0], nr_cnt[0], o_st[0], o_p1[0]);
        end
        for (int f = 0; f < 63; f++) begin
            run_frame(-1, 1'b0);
            model_frame(1'b0);
        end
        run_frame(3, 1'b1);          // would have wrapped the counter
        model_frame(1'b1);
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (obs_tuple(d) !== exp_tuple(d) || hit_cnt[d] !== m_hit[d] || nr_cnt[d] !== m_nr[d]) begin
                nfail++;
                $display("FAIL wrap_hit dut%0d: got %h h=%0d n=%0d, need %h h=%0d n=%0d",
                         d, obs_tuple(d), hit_cnt[d], nr_cnt[d], exp_tuple(d), m_hit[d], m_nr[d]);
            end
        end
    endtask

    task automatic test_stop_on_fb();
        do_stop();
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (obs_tuple(d) !== exp_tuple(d)) begin
                nfail++;
                $display("FAIL done_to_idle dut%0d: got %h, need %h", d, obs_tuple(d), exp_tuple(d));
            end
        end
        do_start();
        for (int f = 0; f < 8; f++) begin
            run_frame(-1, 1'b0);
            model_frame(1'b0);
        end
        for (int s = 0; s < 4; s++) begin
            vs = 1'b1;
            cyc();
        end
        vs = 1'b0; cyc();
        start = 1'b0; cyc();         // fb cycle: start-low wins
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (o_st[d] !== 2'b11 || {o_p1[d], o_p2[d]} !== {4'(m_p1[d]), 4'(m_p2[d])}) begin
                nfail++;
                $display("FAIL stop_on_fb dut%0d: got st=%b p1=%0d p2=%0d, need 11 %0d %0d", d, o_st[d], o_p1[d], o_p2[d], m_p1[d], m_p2[d]);
            end
        end
        vs = 1'b1; cyc();
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (o_st[d] !== 2'b00) begin
                nfail++;
                $display("FAIL stop_then_idle dut%0d: got st=%b, need 00", d, o_st[d]);
            end
        end
        for (int d = 0; d < 2; d++) m_st[d] = 0;
        do_start();
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (obs_tuple(d) !== {2'b01, 8'h00}) begin
                nfail++;
                $display("FAIL restart_clear dut%0d: got %h, need 100", d, obs_tuple(d));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int f = 0; f < 320; f++) begin
            run_frame(-1, 1'b0);
            model_frame(1'b0);
        end
        ncmp++;
        if (o_p1[0] !== 4'd5 || obs_tuple(0) !== exp_tuple(0)) begin
            nfail++;
            $display("FAIL p1_five: got %h, need p1=5 (%h)", obs_tuple(0), exp_tuple(0));
        end
        for (int s = 0; s < 6; s++) begin
            vs = !(s == 4 || s == 5);
            if (s == 5) reset = 1'b1;
            cyc();
        end
        cyc();
        reset = 1'b0; vs = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_p1[d] = 0; m_p2[d] = 0; m_surv[d] = 0;
        end
        cyc();
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (obs_tuple(d) !== 10'd0) begin
                nfail++;
                $display("FAIL reset_mid dut%0d: got %h, need 000", d, obs_tuple(d));
            end
        end
        for (int f = 0; f < 3; f++) begin
            run_frame(-1, 1'b0);
            model_frame(1'b0);
        end
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (o_st[d] !== 2'b00) begin
                nfail++;
                $display("FAIL stay_idle dut%0d: got st=%b, need 00", d, o_st[d]);
            end
        end
        do_start();
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (obs_tuple(d) !== exp_tuple(d) || o_st[d] !== 2'b01) begin
                nfail++;
                $display("FAIL start_after_reset dut%0d: got %h, need %h", d, obs_tuple(d), exp_tuple(d));
            end
        end
    endtask

    task automatic test_random();
        for (int op = 0; op < 200; op++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r < 10) begin
                run_frame(-1, 1'b0);
                model_frame(1'b0);
            end else if (r < 14) begin
                bit vis;
                vis = (r < 12);
                run_frame(int'($urandom_range(0, 4)), vis);
                model_frame(vis);
            end else begin
                do_stop();
                if (r == 15) run_frame(-1, 1'b0);
                do_start();
            end
            for (int d = 0; d < 2; d++) begin
                ncmp++;
                if (obs_tuple(d) !== exp_tuple(d) || hit_cnt[d] !== m_hit[d] || nr_cnt[d] !== m_nr[d]) begin
                    nfail++;
                    $display("FAIL random_op%0d dut%0d: got %h h=%0d n=%0d, need %h h=%0d n=%0d",
                             op, d, obs_tuple(d), hit_cnt[d], nr_cnt[d], exp_tuple(d), m_hit[d], m_nr[d]);
                end
            end
        end
    endtask

    task automatic test_pulse_rules();
        ncmp++;
        if (viol !== 0) begin
            nfail++;
            $display("FAIL pulse_rules: got %0d overlapping or idle-state pulses, need 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_survive();
        test_collision();
        test_stop_on_fb();
        test_reset_mid();
        test_random();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
